an_ord_gen: RTL
===============

AN_ORD_GEN -- requirements
Module: an_ord_gen

Interface
REQ-001 Parameter NUM_CFG, default 2: number of configuration words sent per sequence (1..16).
REQ-002 Parameter CNT_W, default 8: width of the per-word repeat counter.
REQ-003 Parameter IDX_W, default 1: word index width, equal to clog2(NUM_CFG), minimum 1.
REQ-004 clock  input  1: single clock, 125 MHz code-group rate; all logic on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start  input  1: single-cycle request to begin a sequence.
REQ-007 abort  input  1: single-cycle request to terminate a sequence.
REQ-008 cfg_words  input  NUM_CFG*16: config words; word k occupies bits [16k+15:16k].
REQ-009 an_count  input  CNT_W: ordered sets to send per config word.
REQ-010 tx_data  output  8: code-group byte, pre-8b10b.
REQ-011 tx_is_k  output  1: tx_data is a K control character.
REQ-012 busy  output  1: a sequence is accepted or in progress.
REQ-013 done  output  1: single-cycle pulse, sequence completed normally.
REQ-014 word_idx  output  IDX_W: index of the config word being sent; 0 when idle.

Function
REQ-015 Output is one code-group per cycle, continuous, never stalled.
REQ-016 Code points: K28.5=0xBC (k=1), D21.5=0xB5, D2.2=0x42, D16.2=0x50 (k=0).
REQ-017 States: IDLE, CFG, END; IDLE/END emit /I2/ = K28.5, D16.2 (phase 0, 1).
REQ-018 CFG emits ordered sets alternating /C1/ = K28.5, D21.5, cfg[7:0], cfg[15:8] and /C2/ = K28.5, D2.2, cfg[7:0], cfg[15:8]; the first ordered set of a sequence is /C1/.
REQ-019 /C1/-/C2/ alternation continues across word changes, never restarting per word.
REQ-020 start is accepted only in IDLE while not busy; start while busy is ignored.
REQ-021 start seen in IDLE phase 0 is held pending; busy rises the next cycle.
REQ-022 Accepted start: CFG's first K28.5 appears in the cycle after the current /I2/ phase 1 (1 cycle after start sampled in phase 1, 2 cycles in phase 0).
REQ-023 cfg_words and an_count are snapshotted at acceptance; later input changes do not affect the sequence.
REQ-024 an_count = 0 is treated as 1.
REQ-025 After an_count ordered sets for word k, the generator advances to word k+1; after word NUM_CFG-1 it enters END.
REQ-026 END emits one /I2/, pulses done in its phase-1 cycle, then enters IDLE with busy low the next cycle.
REQ-027 abort in any busy state: next cycle emits K28.5 phase 0 of IDLE, busy=0, word_idx=0, done not pulsed, pending start cleared.
REQ-028 abort and start together: abort wins, start discarded.
REQ-029 busy is high from the cycle after acceptance through the done cycle inclusive.

Reset
REQ-030 While reset is high: tx_data=0xBC, tx_is_k=1, busy=0, done=0, word_idx=0, state IDLE phase 0, pending start cleared.
REQ-031 Reset mid-sequence behaves as REQ-030 on the next edge; no partial ordered set is completed.
REQ-032 First cycle after reset release emits D16.2 (IDLE phase 1).

Configuration
REQ-033 Macro AN_ORD_BREAK_LINK_EN defined: each accepted sequence first sends 8 ordered sets (alternating, starting /C1/) carrying config 0x0000, with word_idx=0, then word 0 continues the alternation.
REQ-034 Macro AN_ORD_BREAK_LINK_EN undefined: no break-link prefix; the sequence begins directly with word 0.

Verification
REQ-035 Reset 3 cycles, release -> 0xBC/k=1 during reset, then 0x50, 0xBC, 0x50 ...; busy=0.
REQ-036 NUM_CFG=2, cfg_words={0x4001,0x0001}, an_count=2, start in phase 1 -> next cycle BC B5 01 00, BC 42 01 00, BC B5 01 40, BC 42 01 40, BC 50, with done on the 0x50; word_idx 0 then 1.
REQ-037 Same stimulus, cfg_words changed to 0xFFFF 1 cycle after start -> output bytes unchanged from REQ-036.
REQ-038 an_count=0, NUM_CFG=1, cfg=0x1234 -> exactly one /C1/ (BC B5 34 12), then /I2/, done=1 once.
REQ-039 abort on the 3rd cycle of CFG -> next cycle 0xBC k=1, busy=0, no done; a start 1 cycle later (phase 1) is accepted normally.
REQ-040 With AN_ORD_BREAK_LINK_EN, an_count=1, NUM_CFG=1, cfg=0x0001 -> 8 ordered sets of config 0x0000, then one /C1/ BC B5 01 00, then /I2/ and done.

Source files
------------

// File: rtl/an_ord_gen.sv
// an_ord_gen: 1000BASE-X auto-negotiation ordered-set generator.
// Sends /C1/,/C2/ config ordered sets for NUM_CFG words, then /I2/, with idle /I2/ otherwise.
// Optional feature macro: AN_ORD_BREAK_LINK_EN prepends 8 ordered sets carrying config 0x0000.
module an_ord_gen #(
    parameter int unsigned NUM_CFG = 2,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned IDX_W   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_CFG*16-1:0]  cfg_words,
    input  logic [CNT_W-1:0]       an_count,
    output logic [7:0]             tx_data,
    output logic                   tx_is_k,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       word_idx
);

    localparam int unsigned CFG_W = NUM_CFG * 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CFG  = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D16_2 = 8'h50;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CFG - 1);

    // Current-cycle sequencing state (matches what the outputs show this cycle)
    logic [1:0]       state, state_nxt;
    logic [1:0]       phase, phase_nxt;
    logic             pending, pending_nxt;
    logic             os_c2, os_c2_nxt;
    logic [IDX_W-1:0] widx, widx_nxt;
    logic [CNT_W-1:0] rep_left, rep_left_nxt;
    logic [CFG_W-1:0] snap_cfg, snap_cfg_nxt;
    logic [CNT_W-1:0] snap_cnt, snap_cnt_nxt;
    logic             accept;
`ifdef AN_ORD_BREAK_LINK_EN
    logic             brk, brk_nxt;
    logic [2:0]       brk_left, brk_left_nxt;
`endif

    // Next values of the registered outputs
    logic [7:0]       tx_data_nxt;
    logic             tx_is_k_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [IDX_W-1:0] word_idx_nxt;
    logic [15:0]      word_sel;

    // A repeat count of zero still sends one ordered set
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] n);
        return (n == '0) ? CNT_W'(1) : n;
    endfunction

    // Next-state logic: start acceptance, ordered-set stepping, word advance, abort
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        pending_nxt  = pending;
        os_c2_nxt    = os_c2;
        widx_nxt     = widx;
        rep_left_nxt = rep_left;
        snap_cfg_nxt = snap_cfg;
        snap_cnt_nxt = snap_cnt;
        accept       = 1'b0;
`ifdef AN_ORD_BREAK_LINK_EN
        brk_nxt      = brk;
        brk_left_nxt = brk_left;
`endif
        if (abort && busy) begin
            state_nxt   = ST_IDLE;
            phase_nxt   = 2'd0;
            pending_nxt = 1'b0;
            widx_nxt    = '0;
`ifdef AN_ORD_BREAK_LINK_EN
            brk_nxt     = 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    accept = start && !abort && !busy;
                    if (accept) begin
                        snap_cfg_nxt = cfg_words;
                        snap_cnt_nxt = an_count;
                    end
                    if (phase == 2'd0) begin
                        phase_nxt = 2'd1;
                        if (accept) begin
                            pending_nxt = 1'b1;
                        end
                    end else if (accept || pending) begin
                        state_nxt    = ST_CFG;
                        phase_nxt    = 2'd0;
                        pending_nxt  = 1'b0;
                        os_c2_nxt    = 1'b0;
                        widx_nxt     = '0;
                        rep_left_nxt = eff_count(snap_cnt_nxt);
`ifdef AN_ORD_BREAK_LINK_EN
                        brk_nxt      = 1'b1;
                        brk_left_nxt = 3'd7;
`endif
                    end else begin
                        phase_nxt = 2'd0;
                    end
                end
                ST_CFG: begin
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd3) begin
                        // /C1/-/C2/ alternation runs across prefix and word changes
                        os_c2_nxt = !os_c2;
`ifdef AN_ORD_BREAK_LINK_EN
                        if (brk) begin
                            if (brk_left == 3'd0) begin
                                brk_nxt = 1'b0;
                            end else begin
                                brk_left_nxt = brk_left - 3'd1;
                            end
                        end else
`endif
                        if (rep_left == CNT_W'(1)) begin
                            if (widx == LAST_IDX) begin
                                state_nxt = ST_END;
                                phase_nxt = 2'd0;
                                widx_nxt  = '0;
                            end else begin
                                widx_nxt     = widx + IDX_W'(1);
                                rep_left_nxt = eff_count(snap_cnt);
                            end
                        end else begin
                            rep_left_nxt = rep_left - CNT_W'(1);
                        end
                    end
                end
                ST_END: begin
                    if (phase == 2'd0) begin
                        phase_nxt = 2'd1;
                    end else begin
                        state_nxt = ST_IDLE;
                        phase_nxt = 2'd0;
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    phase_nxt   = 2'd0;
                    pending_nxt = 1'b0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs can be registered
    always_comb begin
        word_sel = '0;
        for (int unsigned k = 0; k < NUM_CFG; k++) begin
            if (widx_nxt == IDX_W'(k)) begin
                word_sel = snap_cfg_nxt[k*16 +: 16];
            end
        end
`ifdef AN_ORD_BREAK_LINK_EN
        if (brk_nxt) begin
            word_sel = '0;
        end
`endif
        tx_data_nxt = K28_5;
        tx_is_k_nxt = 1'b1;
        if (state_nxt == ST_CFG) begin
            case (phase_nxt)
                2'd1: begin
                    tx_data_nxt = os_c2_nxt ? D2_2 : D21_5;
                    tx_is_k_nxt = 1'b0;
                end
                2'd2: begin
                    tx_data_nxt = word_sel[7:0];
                    tx_is_k_nxt = 1'b0;
                end
                2'd3: begin
                    tx_data_nxt = word_sel[15:8];
                    tx_is_k_nxt = 1'b0;
                end
                default: begin
                    tx_data_nxt = K28_5;
                    tx_is_k_nxt = 1'b1;
                end
            endcase
        end else if (phase_nxt[0]) begin
            tx_data_nxt = D16_2;
            tx_is_k_nxt = 1'b0;
        end
        busy_nxt     = pending_nxt || (state_nxt != ST_IDLE);
        done_nxt     = (state_nxt == ST_END) && (phase_nxt == 2'd1);
        word_idx_nxt = (state_nxt == ST_CFG) ? widx_nxt : '0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            phase    <= 2'd0;
            pending  <= 1'b0;
            os_c2    <= 1'b0;
            widx     <= '0;
            rep_left <= '0;
            snap_cfg <= '0;
            snap_cnt <= '0;
`ifdef AN_ORD_BREAK_LINK_EN
            brk      <= 1'b0;
            brk_left <= 3'd0;
`endif
            tx_data  <= K28_5;
            tx_is_k  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_idx <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            pending  <= pending_nxt;
            os_c2    <= os_c2_nxt;
            widx     <= widx_nxt;
            rep_left <= rep_left_nxt;
            snap_cfg <= snap_cfg_nxt;
            snap_cnt <= snap_cnt_nxt;
`ifdef AN_ORD_BREAK_LINK_EN
            brk      <= brk_nxt;
            brk_left <= brk_left_nxt;
`endif
            tx_data  <= tx_data_nxt;
            tx_is_k  <= tx_is_k_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            word_idx <= word_idx_nxt;
        end
    end

endmodule
